// File: rtl/ps2_keycode_source.sv
// PS/2 keyboard receiver that tracks the E0/F0 prefixes and holds the USB-HID code of the pressed key.
// Optional build macro PS2_PARITY_CHECK_EN: drop frames whose odd parity does not hold.
module ps2_keycode_source #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   fall;

  rx_state_t              state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [TW-1:0]          to_cnt_q;
  logic                   byte_vld_q;
  logic                   frame_err_q;
  logic                   parity_ok;

  logic                   ext_q;
  logic                   brk_q;
  logic [7:0]             hid;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= ps2_clk_s;
    end
  end

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;
  always_ff @(posedge Clk) begin
    if (Reset) parity_q <= 1'b0;
    else if (fall && state_q == PARITY) parity_q <= ps2_data_s;
  end
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Receive FSM: one transition per synchronised falling edge of ps2_clk.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        to_cnt_q <= '0;
        case (state_q)
          IDLE: begin
            if (!ps2_data_s) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {ps2_data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: state_q <= STOP;
          STOP: begin
            state_q <= IDLE;
            if (ps2_data_s && parity_ok) byte_vld_q  <= 1'b1;
            else                         frame_err_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
          state_q     <= IDLE;
          to_cnt_q    <= '0;
          frame_err_q <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
    end
  end

  assign frame_err = frame_err_q;

  always_comb begin
    hid = 8'h00;
    case ({ext_q, shift_q})
      9'h175: hid = 8'h52;
      9'h172: hid = 8'h51;
      9'h16B: hid = 8'h50;
      9'h174: hid = 8'h4F;
      9'h01A: hid = 8'h1D;
      9'h022: hid = 8'h1B;
      9'h01D: hid = 8'h1A;
      9'h01B: hid = 8'h16;
      9'h01C: hid = 8'h04;
      9'h023: hid = 8'h07;
      9'h015: hid = 8'h14;
      9'h024: hid = 8'h08;
      default: hid = 8'h00;
    endcase
  end

  // shift_q stays stable for the cycle after acceptance, so it is decoded directly.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      keycode   <= 8'h00;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_vld_q) begin
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (hid != 8'h00) begin
            if (brk_q) begin
              if (keycode == hid) begin
                keycode   <= 8'h00;
                key_valid <= 1'b1;
              end
            end else if (keycode != hid) begin
              keycode   <= hid;
              key_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_source.sv
// Bench for ps2_keycode_source: directed frames plus random key events against a keyboard-level model.
module tb_ps2_keycode_source;

  localparam int TO = 1000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int exp_kv_cnt = 0;
  int exp_fe_cnt = 0;

  logic [7:0] m_kc;
  bit         m_ext;
  bit         m_brk;

  logic [7:0] plain_codes [8] = '{8'h1A, 8'h22, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h15, 8'h24};
  logic [7:0] ext_codes   [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] junk_codes  [3] = '{8'h29, 8'h5A, 8'h76};

  ps2_keycode_source #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hid_of(input bit e, input logic [7:0] c);
    if (e) begin
      case (c)
        8'h75: return 8'h52;
        8'h72: return 8'h51;
        8'h6B: return 8'h50;
        8'h74: return 8'h4F;
        default: return 8'h00;
      endcase
    end
    case (c)
      8'h1A: return 8'h1D;
      8'h22: return 8'h1B;
      8'h1D: return 8'h1A;
      8'h1B: return 8'h16;
      8'h1C: return 8'h04;
      8'h23: return 8'h07;
      8'h15: return 8'h14;
      8'h24: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] h;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      h = hid_of(m_ext, b);
      if (h != 8'h00) begin
        if (m_brk) begin
          if (m_kc == h) m_kc = 8'h00;
        end else m_kc = h;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge Clk) ps2_data = v;
    repeat (4) @(negedge Clk);
    ps2_clk = 1'b0;
    repeat (8) @(negedge Clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    logic [7:0] old_kc;
    bit         accept;
    bit         pulse;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    @(negedge Clk) ps2_data = ~bad_stop;
    repeat (4) @(negedge Clk);
    ps2_clk = 1'b0;
    accept = !bad_stop && !(bad_par && PAR_EN);
    old_kc = m_kc;
    repeat (3) @(negedge Clk);
    check($sformatf("kc_hold_%h", b), keycode, old_kc);
    check($sformatf("kv_early_%h", b), key_valid, 1'b0);
    check($sformatf("ferr_%h", b), frame_err, !accept);
    if (accept) model_byte(b);
    else exp_fe_cnt++;
    pulse = (m_kc != old_kc);
    if (pulse) exp_kv_cnt++;
    @(negedge Clk);
    check($sformatf("kc_new_%h", b), keycode, m_kc);
    check($sformatf("kv_pulse_%h", b), key_valid, pulse);
    check($sformatf("ferr_1cyc_%h", b), frame_err, 1'b0);
    @(negedge Clk);
    check($sformatf("kv_1cyc_%h", b), key_valid, 1'b0);
    repeat (5) @(negedge Clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
  endtask

  task automatic key_event(input bit e, input bit brk, input logic [7:0] c);
    if (e) send_frame(8'hE0, 1'b0, 1'b0);
    if (brk) send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(c, 1'b0, 1'b0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_kv_cnt"}, kv_cnt, exp_kv_cnt);
    check({tag, "_fe_cnt"}, fe_cnt, exp_fe_cnt);
  endtask

  initial begin
    // clock/reset
    Reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    m_kc = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_keycode", keycode, 8'h00);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);

    // w make / break
    key_event(1'b0, 1'b0, 8'h1D);
    key_event(1'b0, 1'b1, 8'h1D);
    check_counts("w_make_break");

    // extended up make / break
    key_event(1'b1, 1'b0, 8'h75);
    check("up_make", keycode, 8'h52);
    key_event(1'b1, 1'b1, 8'h75);
    check("up_break", keycode, 8'h00);

    // a, d, release a: d stays held
    key_event(1'b0, 1'b0, 8'h1C);
    key_event(1'b0, 1'b0, 8'h23);
    key_event(1'b0, 1'b1, 8'h1C);
    check("a_d_release_a", keycode, 8'h07);
    check_counts("a_d");

    // typematic repeat of w
    key_event(1'b0, 1'b0, 8'h1D);
    key_event(1'b0, 1'b0, 8'h1D);
    key_event(1'b0, 1'b0, 8'h1D);
    check_counts("typematic");

    // bad stop bit, then a stalled frame that must time out
    send_frame(8'h22, 1'b1, 1'b0);
    send_partial(8'h22, 4);
    repeat (TO + 40) @(negedge Clk);
    exp_fe_cnt++;
    check_counts("stop_timeout");
    check("kc_after_errors", keycode, m_kc);
    key_event(1'b0, 1'b0, 8'h22);
    check("x_after_errors", keycode, 8'h1B);

    // bad parity: dropped only when parity checking is built in
    key_event(1'b0, 1'b1, 8'h22);
    send_frame(8'h1D, 1'b0, 1'b1);
    check_counts("parity");

    // unmapped codes only clear prefixes
    key_event(1'b0, 1'b0, 8'h1B);
    key_event(1'b1, 1'b1, 8'h1B);
    key_event(1'b0, 1'b0, 8'h29);
    check("unmapped", keycode, 8'h16);

    // random key events
    for (int n = 0; n < 30; n++) begin
      int kind;
      bit brk;
      kind = $urandom_range(0, 9);
      brk  = $urandom_range(0, 2) == 0;
      if (kind < 5)      key_event(1'b0, brk, plain_codes[$urandom_range(0, 7)]);
      else if (kind < 8) key_event(1'b1, brk, ext_codes[$urandom_range(0, 3)]);
      else if (kind < 9) key_event($urandom_range(0, 1) == 1, brk, junk_codes[$urandom_range(0, 2)]);
      else               send_frame(plain_codes[$urandom_range(0, 7)], 1'b1, 1'b0);
    end
    check_counts("random");

    // reset in the middle of a frame
    key_event(1'b0, 1'b0, 8'h1D);
    send_partial(8'h24, 3);
    @(negedge Clk) Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    m_kc = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    @(negedge Clk);
    check("midframe_rst_kc", keycode, 8'h00);
    key_event(1'b0, 1'b0, 8'h15);
    check("q_after_reset", keycode, 8'h14);
    repeat (20) @(negedge Clk);
    check_counts("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    fails++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
